// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive 4-input truth-table sweep and compare engine
// Optional: define TTC_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_checker #(
    parameter logic [15:0] EXPECTED      = 16'h6996,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dut_f,
    output logic [3:0]  dut_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail_idx,
    output logic [15:0] captured
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ffi_q, ffi_d;
    logic [15:0] cap_q, cap_d;

    logic        mismatch;
    logic        stop_now;

    assign mismatch = (dut_f != EXPECTED[vec_q]);

`ifdef TTC_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        cap_d   = cap_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = 4'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 5'd0;
                    ffi_d   = 4'd0;
                    cap_d   = 16'h0000;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                cap_d[vec_q] = dut_f;
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (err_q == 5'd0) begin
                        ffi_d = vec_q;
                    end
                end
                // In stop-on-fail builds vec_q is left on the failing vector.
                if (vec_q == 4'd15 || stop_now) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            ffi_q   <= 4'd0;
            cap_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            cap_q   <= cap_d;
        end
    end

    assign dut_in         = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;
    assign captured       = cap_q;

endmodule
